// File: rtl/spi_result_tx.sv
// spi_result_tx: SPI slave response engine serialising cost, queued digits or status onto MISO.
module spi_result_tx #(
  parameter int DATA_W     = 8,
  parameter int COST_BYTES = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int DIGIT_W    = 4
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic                             shift_spi,
  input  logic                             ss_n,
  input  logic                             cmd_valid,
  input  logic [DATA_W-1:0]                cmd,
  input  logic                             result_valid,
  input  logic [DIGIT_W-1:0]               result_digit,
  input  logic                             cost_valid,
  input  logic [COST_BYTES*DATA_W-1:0]     cost_value,
  output logic                             miso,
  output logic                             miso_oe,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
  output logic                             overflow,
  output logic                             busy
);
  localparam int CW = $clog2(DATA_W);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;
  localparam int WW = $clog2(COST_BYTES) + 1;
  localparam logic [1:0] OP_COST = 2'd1, OP_DIGIT = 2'd2, OP_STATUS = 2'd3;
  typedef enum logic [1:0] {IDLE, WAIT_COST, LOAD, SHIFT} state_t;
  state_t state;
  logic [1:0] op;
  logic [DATA_W-1:0] sreg, cost_word, digit_word, status_word, first_word;
  logic [CW-1:0] bit_cnt;
  logic [WW-1:0] words_left, sel;
  logic [COST_BYTES*DATA_W-1:0] cost_reg;
  logic cost_avail;
  logic [DIGIT_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count;
  logic word_end, done, pop, push, cmd_ok;
  assign word_end = shift_spi && !ss_n && bit_cnt == CW'(DATA_W - 1);
  assign done = state == SHIFT && word_end && words_left == '0;
  assign pop = state == LOAD && op == OP_DIGIT && count != '0;
  assign push = result_valid && (count != NW'(FIFO_DEPTH) || pop);
  assign cmd_ok = cmd_valid && cmd != '0 && cmd < DATA_W'(4);
  // LOAD sends the most significant cost byte; later boundaries pick byte words_left-1
  assign sel = state == LOAD ? WW'(COST_BYTES - 1) : words_left - WW'(1);
  assign cost_word = DATA_W'(cost_reg >> (sel * DATA_W));
  assign digit_word = count != '0 ? DATA_W'(mem[rd_ptr]) : '1;
  assign status_word = {overflow, cost_avail, (DATA_W-2)'(count)};
  assign first_word = op == OP_COST ? cost_word : op == OP_DIGIT ? digit_word : status_word;
  assign miso = ~ss_n & sreg[DATA_W-1];
  assign miso_oe = ~ss_n;
  assign fifo_count = count;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= IDLE;
      op <= '0;
      sreg <= '1;
      bit_cnt <= '0;
      words_left <= '0;
    end else begin
      bit_cnt <= ss_n ? '0 : shift_spi ? (bit_cnt == CW'(DATA_W - 1) ? '0 : bit_cnt + CW'(1)) : bit_cnt;
      if (ss_n && state != IDLE) begin
        state <= IDLE;
        sreg <= '1;
      end else
        case (state)
          IDLE: if (cmd_ok) begin
            op <= cmd[1:0];
            state <= (cmd == DATA_W'(1) && !cost_avail) ? WAIT_COST : LOAD;
          end
          WAIT_COST: state <= (cost_valid && bit_cnt == '0 && !shift_spi) ? LOAD : word_end ? IDLE : WAIT_COST;
          LOAD: begin
            sreg <= first_word;
            words_left <= op == OP_COST ? WW'(COST_BYTES - 1) : '0;
            state <= SHIFT;
          end
          default: if (word_end && words_left != '0) begin
            sreg <= cost_word;
            words_left <= words_left - WW'(1);
          end else if (word_end) begin
            sreg <= '1;
            state <= IDLE;
          end else if (shift_spi)
            sreg <= {sreg[DATA_W-2:0], 1'b1};
        endcase
    end
  // a fresh capture outranks the completion clear so the new value stays readable
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      cost_reg <= '0;
      cost_avail <= 1'b0;
      overflow <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (cost_valid) cost_reg <= cost_value;
      cost_avail <= cost_valid ? 1'b1 : (done && op == OP_COST) ? 1'b0 : cost_avail;
      overflow <= (result_valid && !push) ? 1'b1 : (done && op == OP_STATUS) ? 1'b0 : overflow;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + NW'(push) - NW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= result_digit;
endmodule

// File: tb/tb_spi_result_tx.sv
// tb_spi_result_tx: directed scenarios for the SPI response engine with hand-computed expectations.
module tb_spi_result_tx;
  logic clk = 1'b0, n_rst = 1'b0, shift_spi = 1'b0, ss_n = 1'b0, cmd_valid = 1'b0;
  logic result_valid = 1'b0, cost_valid = 1'b0;
  logic [7:0] cmd = '0;
  logic [3:0] result_digit = '0;
  logic [15:0] cost_value = '0;
  logic miso, miso_oe, overflow, busy;
  logic [2:0] fifo_count;
  logic [7:0] w;
  int vectors = 0, miscompares = 0;

  spi_result_tx #(.DATA_W(8), .COST_BYTES(2), .FIFO_DEPTH(4), .DIGIT_W(4)) dut (
    .clk(clk), .n_rst(n_rst), .shift_spi(shift_spi), .ss_n(ss_n), .cmd_valid(cmd_valid),
    .cmd(cmd), .result_valid(result_valid), .result_digit(result_digit), .cost_valid(cost_valid),
    .cost_value(cost_value), .miso(miso), .miso_oe(miso_oe), .fifo_count(fifo_count),
    .overflow(overflow), .busy(busy));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_digit(input logic [3:0] d);
    result_digit = d;
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    cmd = c;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic load_cost(input logic [15:0] v);
    cost_value = v;
    cost_valid = 1'b1;
    tick();
    cost_valid = 1'b0;
  endtask

  task automatic read_word(output logic [7:0] r);
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r = {r[6:0], miso};
      shift_spi = 1'b1;
      tick();
    end
    shift_spi = 1'b0;
  endtask

  task automatic shifts(input int n);
    for (int i = 0; i < n; i++) begin
      shift_spi = 1'b1;
      tick();
    end
    shift_spi = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    ss_n = 1'b1;
    tick();
    vectors++; if (miso !== 1'b0 || miso_oe !== 1'b0) begin miscompares++; $display("FAIL reset_ss_high miso=%b oe=%b expected 0 0", miso, miso_oe); end
    ss_n = 1'b0;
    tick();
    vectors++; if ({miso, miso_oe, busy, overflow, fifo_count} !== 7'b1100_000) begin miscompares++; $display("FAIL reset_state got %b expected 1100000", {miso, miso_oe, busy, overflow, fifo_count}); end
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_digit();
    push_digit(4'd3);
    push_digit(4'd7);
    vectors++; if (fifo_count !== 3'd2) begin miscompares++; $display("FAIL digit_count2 got %0d expected 2", fifo_count); end
    send_cmd(8'h02);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL digit_busy got %b expected 1", busy); end
    read_word(w);
    vectors++; if (w !== 8'h03) begin miscompares++; $display("FAIL digit_first got %h expected 03", w); end
    vectors++; if (fifo_count !== 3'd1) begin miscompares++; $display("FAIL digit_count1 got %0d expected 1", fifo_count); end
    send_cmd(8'h02);
    read_word(w);
    vectors++; if (w !== 8'h07) begin miscompares++; $display("FAIL digit_second got %h expected 07", w); end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL digit_count0 got %0d expected 0", fifo_count); end
    send_cmd(8'h02);
    read_word(w);
    vectors++; if (w !== 8'hFF) begin miscompares++; $display("FAIL digit_empty got %h expected ff", w); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL digit_idle got %b expected 0", busy); end
  endtask

  task automatic test_invalid();
    send_cmd(8'h55);
    vectors++; if (busy !== 1'b0 || miso !== 1'b1) begin miscompares++; $display("FAIL invalid_cmd busy=%b miso=%b expected 0 1", busy, miso); end
    send_cmd(8'h00);
    vectors++; if (busy !== 1'b0 || miso !== 1'b1) begin miscompares++; $display("FAIL zero_cmd busy=%b miso=%b expected 0 1", busy, miso); end
  endtask

  task automatic test_cost();
    load_cost(16'hA55A);
    send_cmd(8'h01);
    read_word(w);
    vectors++; if (w !== 8'hA5) begin miscompares++; $display("FAIL cost_hi got %h expected a5", w); end
    read_word(w);
    vectors++; if (w !== 8'h5A) begin miscompares++; $display("FAIL cost_lo got %h expected 5a", w); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL cost_idle got %b expected 0", busy); end
    send_cmd(8'h03);
    read_word(w);
    vectors++; if (w !== 8'h00) begin miscompares++; $display("FAIL cost_cleared_status got %h expected 00", w); end
  endtask

  task automatic test_wait_cost();
    send_cmd(8'h01);
    vectors++; if (busy !== 1'b1 || miso !== 1'b1) begin miscompares++; $display("FAIL wait_cost busy=%b miso=%b expected 1 1", busy, miso); end
    load_cost(16'h1234);
    tick();
    read_word(w);
    vectors++; if (w !== 8'h12) begin miscompares++; $display("FAIL wait_cost_hi got %h expected 12", w); end
    read_word(w);
    vectors++; if (w !== 8'h34) begin miscompares++; $display("FAIL wait_cost_lo got %h expected 34", w); end
    send_cmd(8'h01);
    read_word(w);
    vectors++; if (w !== 8'hFF) begin miscompares++; $display("FAIL wait_cost_timeout got %h expected ff", w); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL wait_cost_idle got %b expected 0", busy); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) push_digit(4'(i));
    vectors++; if (fifo_count !== 3'd4 || overflow !== 1'b1) begin miscompares++; $display("FAIL overflow_set count=%0d ovf=%b expected 4 1", fifo_count, overflow); end
    send_cmd(8'h03);
    read_word(w);
    vectors++; if (w !== 8'h84) begin miscompares++; $display("FAIL status_ovf got %h expected 84", w); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL overflow_clear got %b expected 0", overflow); end
    send_cmd(8'h03);
    read_word(w);
    vectors++; if (w !== 8'h04) begin miscompares++; $display("FAIL status_again got %h expected 04", w); end
  endtask

  task automatic test_abort();
    load_cost(16'hA55A);
    send_cmd(8'h01);
    shifts(3);
    ss_n = 1'b1;
    tick();
    vectors++; if ({busy, miso, miso_oe} !== 3'b000) begin miscompares++; $display("FAIL abort got %b expected 000", {busy, miso, miso_oe}); end
    ss_n = 1'b0;
    tick();
    send_cmd(8'h03);
    read_word(w);
    vectors++; if (w !== 8'h44) begin miscompares++; $display("FAIL abort_status got %h expected 44", w); end
    send_cmd(8'h01);
    read_word(w);
    vectors++; if (w !== 8'hA5) begin miscompares++; $display("FAIL abort_retry_hi got %h expected a5", w); end
    read_word(w);
    vectors++; if (w !== 8'h5A) begin miscompares++; $display("FAIL abort_retry_lo got %h expected 5a", w); end
  endtask

  task automatic test_back_to_back();
    cmd = 8'h02;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    result_digit = 4'd9;
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    tick();
    vectors++; if (fifo_count !== 3'd4 || overflow !== 1'b0) begin miscompares++; $display("FAIL full_push_pop count=%0d ovf=%b expected 4 0", fifo_count, overflow); end
    read_word(w);
    vectors++; if (w !== 8'h01) begin miscompares++; $display("FAIL full_pop got %h expected 01", w); end
    for (int i = 0; i < 4; i++) begin
      send_cmd(8'h02);
      read_word(w);
      vectors++; if (w !== (i == 3 ? 8'h09 : 8'(i + 2))) begin miscompares++; $display("FAIL drain_%0d got %h expected %h", i, w, (i == 3 ? 8'h09 : 8'(i + 2))); end
    end
    cmd = 8'h02;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    result_digit = 4'd6;
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    tick();
    read_word(w);
    vectors++; if (w !== 8'hFF || fifo_count !== 3'd1) begin miscompares++; $display("FAIL empty_push_pop word=%h count=%0d expected ff 1", w, fifo_count); end
    send_cmd(8'h02);
    read_word(w);
    vectors++; if (w !== 8'h06) begin miscompares++; $display("FAIL empty_pushed got %h expected 06", w); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) push_digit(4'(i + 8));
    send_cmd(8'h02);
    shifts(3);
    vectors++; if (busy !== 1'b1 || overflow !== 1'b1 || fifo_count !== 3'd3) begin miscompares++; $display("FAIL pre_reset busy=%b ovf=%b count=%0d expected 1 1 3", busy, overflow, fifo_count); end
    n_rst = 1'b0;
    #1;
    vectors++; if ({miso, miso_oe, busy, overflow, fifo_count} !== 7'b1100_000) begin miscompares++; $display("FAIL mid_reset got %b expected 1100000", {miso, miso_oe, busy, overflow, fifo_count}); end
    tick();
    n_rst = 1'b1;
    tick();
    send_cmd(8'h02);
    read_word(w);
    vectors++; if (w !== 8'hFF) begin miscompares++; $display("FAIL post_reset_digit got %h expected ff", w); end
    send_cmd(8'h03);
    read_word(w);
    vectors++; if (w !== 8'h00) begin miscompares++; $display("FAIL post_reset_status got %h expected 00", w); end
  endtask

  initial begin
    test_reset();
    test_digit();
    test_invalid();
    test_cost();
    test_wait_cost();
    test_overflow();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/spi_result_tx.md
Name: spi_result_tx

Overview:
- Parametrised SPI slave transmit engine for the digit-recognizer response path.
- Decodes received command words and serialises multi-word responses onto MISO, MSB first: cost value, queued digit results, or a status word.
- Buffers network results in a small FIFO so the host can read several classifications back-to-back.
- Sits between the SPI receive deserialiser (supplies cmd/shift_spi) and the pad-level MISO driver.

Parameters:
- DATA_W, 8: SPI word width in bits.
- COST_BYTES, 2: cost value width in words; cost bus is COST_BYTES*DATA_W bits.
- FIFO_DEPTH, 4: digit result queue depth; must be a power of two, 2..32.
- DIGIT_W, 4: detected digit width; must be at most DATA_W.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- shift_spi  in  1  one-cycle pulse per SCK shift edge, already synchronised to clk
- ss_n  in  1  slave select, active low, synchronised
- cmd_valid  in  1  one-cycle pulse: cmd holds a complete received word
- cmd  in  DATA_W  received command word
- result_valid  in  1  one-cycle pulse: push result_digit into the FIFO
- result_digit  in  DIGIT_W  classified digit
- cost_valid  in  1  one-cycle pulse: capture cost_value
- cost_value  in  COST_BYTES*DATA_W  network cost
- miso  out  1  serial data; 0 when ss_n=1
- miso_oe  out  1  equals ~ss_n; the pad driver tri-states on 0
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries queued
- overflow  out  1  sticky: a push was dropped while the FIFO was full
- busy  out  1  1 in every state except IDLE

Behaviour:
- Reset values:
  - state IDLE; shift register all ones.
  - bit counter 0, words_left 0.
  - FIFO empty; cost_avail 0; overflow 0; busy 0.
  - miso = ~ss_n & 1.
- Commands are accepted only in IDLE; cmd_valid in any other state is ignored.
  - 0x01 READ_COST
  - 0x02 READ_DIGIT
  - 0x03 READ_STATUS
  - any other value: stay in IDLE; the shift register stays all ones (0xFF fill).
- States:
  - IDLE: on a valid command go to LOAD. Exception: READ_COST with cost_avail=0 goes to WAIT_COST.
  - WAIT_COST: shift register holds ones. If cost_valid arrives before any shift_spi pulse, go to LOAD. If DATA_W shift pulses complete first, go to IDLE (host sees 0xFF).
  - LOAD: exactly one cycle. Loads the first response word and sets words_left, then goes to SHIFT.
    - READ_COST: most significant cost byte first; words_left = COST_BYTES-1.
    - READ_DIGIT: pops the FIFO head, zero-extended; if the FIFO is empty, loads all ones and pops nothing. words_left = 0.
    - READ_STATUS: {overflow, cost_avail, fifo_count zero-extended}; words_left = 0.
  - SHIFT: each shift_spi shifts left with a 1 shifted in; miso = shift register MSB. On the DATA_W-th pulse:
    - words_left>0: the next cost byte is loaded in that same cycle and words_left decrements (no gap between words).
    - words_left=0: go to IDLE with the shift register all ones.
- Completion side effects, applied on the last shift pulse of the response:
  - READ_COST clears cost_avail.
  - READ_STATUS clears overflow.
- Bit counter: counts shift_spi pulses modulo DATA_W and wraps to 0 at each word boundary. It is cleared whenever ss_n=1.
- ss_n rising while busy:
  - Immediate return to IDLE; shift register set to ones; counter cleared.
  - A popped digit is lost.
  - cost_avail and overflow are not cleared.
- Cost register:
  - cost_valid captures cost_value and sets cost_avail.
  - cost_valid in the same cycle as the READ_COST completion clear: set wins, and the new value is kept.
  - cost_valid during an active READ_COST: the value updates, but the bytes already in flight are unchanged. Later bytes come from the new value.
- FIFO:
  - Push with full and no pop: data dropped, overflow set.
  - Push and pop in the same cycle when full: both occur, no overflow.
  - Push and pop when empty: the pop returns empty (0xFF sent) and the push is stored.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: the first response bit is on miso 2 clk cycles after cmd_valid (IDLE→LOAD→SHIFT), before the next shift_spi pulse. The host must leave at least 2 clk between the command word and the response word.

Test Plan:
- Push digits 3, 7; send READ_DIGIT twice, 8 shifts each → miso 0x03 then 0x07; third READ_DIGIT → 0xFF; fifo_count 2→1→0.
- cost_valid with 0xA55A, then READ_COST, 16 shifts → miso 0xA5, 0x5A contiguous with no gap; cost_avail ends at 0.
- READ_COST with cost_avail=0, cost_valid=0x1234 after 2 clk and before any shift → 0x12, 0x34. Repeat with no cost_valid → 8 ones, back to IDLE.
- Push 5 digits with FIFO_DEPTH=4 → 5th dropped, overflow=1; READ_STATUS → 0b1_0_000100; read status again → bit7=0.
- READ_COST started, ss_n deasserted after 3 shifts → IDLE, busy=0, miso=0, miso_oe=0, cost_avail still 1. Next READ_COST → full 0xA5 0x5A.
- Assert n_rst mid-SHIFT → all outputs at reset values; the FIFO is empty afterwards.
